pri_enc_pend: RTL

//  Parametrised, registered priority encoder with pending-request memory.
//  - Captures request pulses into a sticky pending vector and issues one index per accepted transfer.
//  - Output is a valid/ready handshake; the highest-priority pending request is served first.
//  - Sits between interrupt/event sources and a single serial consumer.
//  - Successor to the 8:3 combinational encoder.

---
 rtl/pri_enc_pkg.sv | 42 ++++
 rtl/pri_enc_pend_find.sv | 29 ++
 rtl/pri_enc_pend.sv | 83 ++++++++
 3 files changed

// File: rtl/pri_enc_pkg.sv
// Shared helpers for the pending-request priority encoder: width math,
// MSB-first search and the wrapping decrement used by the round-robin search.
package pri_enc_pkg;

  localparam int MAX_REQ   = 64;
  localparam int MAX_IDX_W = 6;

  typedef struct packed {
    logic                 found;
    logic [MAX_IDX_W-1:0] idx;
  } find_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << r) < v) r = r + 1;
    end
    return r;
  endfunction

  function automatic find_t find_msb(input logic [MAX_REQ-1:0] vec);
    find_t res;
    res = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (vec[MAX_IDX_W'(i)]) begin
        res.found = 1'b1;
        res.idx   = MAX_IDX_W'(i);
      end
    end
    return res;
  endfunction

  // (base - off) modulo n, for base in [0,n) and off in [0,n)
  function automatic int wrap_dec(input int base, input int off, input int n);
    int p;
    p = base - off;
    if (p < 0) p = p + n;
    return p;
  endfunction

endpackage

// File: rtl/pri_enc_pend_find.sv
// Combinational descending find-first with wrap: searches vec from start
// downward, wrapping N_REQ-1 -> 0, and returns the first set index.
module pri_enc_find
  import pri_enc_pkg::*;
#(
  parameter int N_REQ = 8,
  parameter int IDX_W = 3
) (
  input  logic [N_REQ-1:0] vec,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [MAX_REQ-1:0] rot;
  find_t              res;

  // rot[N_REQ-1] is vec[start], rot[N_REQ-2] is vec[start-1], and so on
  always_comb begin
    rot = '0;
    for (int j = 0; j < N_REQ; j++) begin
      rot[MAX_IDX_W'(j)] = vec[IDX_W'(wrap_dec(int'(start), N_REQ - 1 - j, N_REQ))];
    end
    res   = find_msb(rot);
    found = res.found;
    idx   = IDX_W'(wrap_dec(int'(start), N_REQ - 1 - int'(res.idx), N_REQ));
  end

endmodule

// File: rtl/pri_enc_pend.sv
// Registered priority encoder with sticky pending memory and valid/ready issue.
// Define PRI_ENC_PEND_RR_EN for round-robin search; default is fixed MSB-first.
module pri_enc_pend
  import pri_enc_pkg::*;
#(
  parameter  int N_REQ = 8,
  localparam int IDX_W = clog2(N_REQ),
  localparam int CNT_W = clog2(N_REQ + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic [N_REQ-1:0] pending,
  output logic [CNT_W-1:0] pend_cnt,
  output logic             dup
);

  logic [N_REQ-1:0] set;
  logic [N_REQ-1:0] issue_mask;
  logic [N_REQ-1:0] pending_nxt;
  logic             slot_free;
  logic             found;
  logic             issue;
  logic [IDX_W-1:0] find_idx;
  logic [IDX_W-1:0] start;

`ifdef PRI_ENC_PEND_RR_EN
  logic [IDX_W-1:0] rr_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rr_ptr <= '0;
    else if (issue) rr_ptr <= find_idx;
  end

  // last-served source gets lowest priority; rr_ptr=0 starts at the top
  assign start = (rr_ptr == '0) ? IDX_W'(N_REQ - 1) : rr_ptr - IDX_W'(1);
`else
  assign start = IDX_W'(N_REQ - 1);
`endif

  pri_enc_find #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_find (
    .vec   (pending),
    .start (start),
    .found (found),
    .idx   (find_idx)
  );

  // a new capture on the bit being issued wins, so that source is served again
  always_comb begin
    set        = en ? req : '0;
    slot_free  = !out_valid || out_ready;
    issue      = slot_free && found;
    issue_mask = '0;
    if (issue) issue_mask[find_idx] = 1'b1;
    pending_nxt = (pending & ~issue_mask) | set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      pend_cnt  <= '0;
      dup       <= 1'b0;
      out_valid <= 1'b0;
      out_idx   <= '0;
    end else begin
      pending  <= pending_nxt;
      pend_cnt <= CNT_W'($countones(pending_nxt));
      dup      <= |(set & pending & ~issue_mask);
      if (slot_free) begin
        out_valid <= found;
        if (found) out_idx <= find_idx;
      end
    end
  end

endmodule
